lcd_fb_scan_ctrl: RTL

Read-side scan controller for the 1-bit-per-pixel LCD framebuffer (16384 × 1 dual-port RAM, read port B). On a start pulse it walks the framebuffer in row-major order, issues single-bit reads, and packs 8 pixels MSB-first into bytes. It delivers each byte to the downstream LCD serial/parallel driver over a valid/ready handshake. It sits between the framebuffer RAM and the LCD interface engine in the wb_LCD subsystem, with all signals on the LCD pixel clock domain.

---
 rtl/lcd_fb_scan_ctrl_if.sv | 28 ++
 rtl/lcd_fb_scan_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/lcd_fb_scan_ctrl_if.sv
// Handshake/bus bundle for lcd_fb_scan_ctrl: control, framebuffer read port
// and packed-byte stream. The master modport is the scan controller side.
interface lcd_fb_scan_ctrl_if #(
    parameter int ADDR_W = 14
) ();
    logic              start;
    logic              abort;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_dout;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              byte_sol;
    logic              byte_eof;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, ram_dout, byte_ready,
        output ram_en, ram_addr, byte_data, byte_valid, byte_sol, byte_eof, busy, done
    );

    modport slave (
        output start, abort, ram_dout, byte_ready,
        input  ram_en, ram_addr, byte_data, byte_valid, byte_sol, byte_eof, busy, done
    );
endinterface

// File: rtl/lcd_fb_scan_ctrl.sv
// Framebuffer read-side scanner: reads 1-bit pixels row-major, packs 8 per byte MSB-first.
// Define LCD_FB_SCAN_CONT_EN for continuous refresh (frame restarts from DONE).
module lcd_fb_scan_ctrl #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128,
    parameter int ADDR_W = 14
) (
    input  logic               clk,
    input  logic               reset,
    lcd_fb_scan_ctrl_if.master bus
);
    localparam int unsigned       NPIX      = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] LAST_BCOL = ADDR_W'(WIDTH / 8 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_OUT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pix;
    logic [2:0]        r_bit;
    logic [6:0]        r_sr;
    logic [ADDR_W-1:0] r_bcol;
    logic              r_ram_en;
    logic [7:0]        r_byte_data;
    logic              r_byte_valid;
    logic              r_byte_sol;
    logic              r_byte_eof;
    logic              r_busy;
    logic              r_done;
    logic              w_xfer;

    assign w_xfer         = r_byte_valid && bus.byte_ready;

    assign bus.ram_en     = r_ram_en;
    assign bus.ram_addr   = r_pix;
    assign bus.byte_data  = r_byte_data;
    assign bus.byte_valid = r_byte_valid;
    assign bus.byte_sol   = r_byte_sol;
    assign bus.byte_eof   = r_byte_eof;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pix        <= '0;
            r_bit        <= '0;
            r_sr         <= '0;
            r_bcol       <= '0;
            r_ram_en     <= 1'b0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_byte_sol   <= 1'b0;
            r_byte_eof   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (bus.abort && (r_state != S_IDLE)) begin
            r_state      <= S_IDLE;
            r_pix        <= '0;
            r_bit        <= '0;
            r_bcol       <= '0;
            r_ram_en     <= 1'b0;
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_byte_sol   <= 1'b0;
            r_byte_eof   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_state  <= S_FETCH;
                        r_pix    <= '0;
                        r_bit    <= '0;
                        r_bcol   <= '0;
                        r_ram_en <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end

                // r_pix doubles as the read address; it holds on the 8th read so it
                // never runs past the last pixel of the frame.
                S_FETCH: begin
                    r_bit <= r_bit + 3'd1;
                    if (r_bit != 3'd0) begin
                        r_sr <= {r_sr[5:0], bus.ram_dout};
                    end
                    if (r_bit == 3'd7) begin
                        r_ram_en <= 1'b0;
                        r_state  <= S_LAST;
                    end else begin
                        r_pix <= r_pix + 1'b1;
                    end
                end

                S_LAST: begin
                    r_byte_data  <= {r_sr, bus.ram_dout};
                    r_byte_sol   <= (r_bcol == '0);
                    r_byte_eof   <= (r_pix == LAST_ADDR);
                    r_byte_valid <= 1'b1;
                    r_state      <= S_OUT;
                end

                S_OUT: begin
                    if (w_xfer) begin
                        r_byte_valid <= 1'b0;
                        if (r_byte_eof) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= S_FETCH;
                            r_ram_en <= 1'b1;
                            r_pix    <= r_pix + 1'b1;
                            r_bcol   <= (r_bcol == LAST_BCOL) ? '0 : r_bcol + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_done <= 1'b0;
`ifdef LCD_FB_SCAN_CONT_EN
                    r_state  <= S_FETCH;
                    r_pix    <= '0;
                    r_bit    <= '0;
                    r_bcol   <= '0;
                    r_ram_en <= 1'b1;
`else
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
`endif
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
